// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates a fetch port and a data port onto one single-ported memory
// Ports: clk/rst (async active-low); if_req/if_addr fetch request; mem_req/mem_we/mem_addr/mem_wdata
// data request; m_valid/m_we/m_addr/m_wdata memory request, m_ready/m_rdata completion;
// if_ack/mem_ack one-cycle completions with rdata; sel address-mux owner (1 = data); if_stall/mem_stall.
module mem_port_arbiter #(
  parameter int N = 32,
  parameter int MAX_CONSEC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         if_req,
  input  logic [N-1:0] if_addr,
  input  logic         mem_req,
  input  logic         mem_we,
  input  logic [N-1:0] mem_addr,
  input  logic [N-1:0] mem_wdata,
  output logic         m_valid,
  output logic         m_we,
  output logic [N-1:0] m_addr,
  output logic [N-1:0] m_wdata,
  input  logic         m_ready,
  input  logic [N-1:0] m_rdata,
  output logic         if_ack,
  output logic         mem_ack,
  output logic [N-1:0] rdata,
  output logic         sel,
  output logic         if_stall,
  output logic         mem_stall
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, ACK} state_t;
  state_t state, state_nxt;
  logic [3:0] consec_cnt;
  logic grant_mem, grant_if;
  // Data wins unless the fetch has already been passed over MAX_CONSEC times in a row.
  always_comb begin
    grant_mem = mem_req & ~(if_req & (consec_cnt == 4'(MAX_CONSEC)));
    grant_if  = if_req & ~grant_mem;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:             state_nxt = grant_mem ? BUSY_MEM : grant_if ? BUSY_IF : IDLE;
      BUSY_IF, BUSY_MEM: state_nxt = m_ready ? ACK : state;
      ACK:              state_nxt = IDLE;
    endcase
  end
  always_comb begin
    m_valid   = (state == BUSY_IF) | (state == BUSY_MEM);
    if_ack    = (state == ACK) & ~sel;
    mem_ack   = (state == ACK) & sel;
    if_stall  = if_req & ~if_ack;
    mem_stall = mem_req & ~mem_ack;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sel        <= 1'b0;
      consec_cnt <= '0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      rdata      <= '0;
    end else begin
      if (state == IDLE && (grant_mem | grant_if)) begin
        sel        <= grant_mem;
        m_we       <= grant_mem & mem_we;
        m_addr     <= grant_mem ? mem_addr : if_addr;
        m_wdata    <= grant_mem ? mem_wdata : '0;
        consec_cnt <= (grant_mem & if_req) ? consec_cnt + 4'd1 : 4'd0;
      end
      if (m_valid && m_ready) rdata <= m_rdata;
    end
endmodule
